// File: rtl/module_debouncer_bank.sv
// Parallel push-button debouncer bank.
// Each channel has a 2-FF synchroniser, a stable-count filter, press/release pulses
// and long-press/auto-repeat pulses. A registered encoder reports the lowest
// channel with a press or repeat event.
module module_debouncer_bank #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned STABLE_CYC = 8,
  parameter int unsigned HOLD_CYC   = 20,
  parameter int unsigned RPT_CYC    = 5,
  parameter bit          RPT_EN     = 1'b1,
  localparam int unsigned IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,        // synchronous, active-low
  input  logic             tick,
  input  logic [N_CH-1:0]  btn,
  output logic [N_CH-1:0]  level,
  output logic [N_CH-1:0]  press,
  output logic [N_CH-1:0]  rel,        // release pulse; "release" is a reserved word
  output logic [N_CH-1:0]  rpt,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_idx
);

  localparam int unsigned SCNT_W   = $clog2(STABLE_CYC);
  localparam int unsigned HCNT_MAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
  localparam int unsigned HCNT_W   = $clog2(HCNT_MAX + 1);

  logic [N_CH-1:0]   s1, s2;
  logic [SCNT_W-1:0] scnt     [N_CH];
  logic [SCNT_W-1:0] scnt_nxt [N_CH];
  logic [HCNT_W-1:0] hcnt     [N_CH];
  logic [HCNT_W-1:0] hcnt_nxt [N_CH];
  // phase=0: waiting for first long-press; phase=1: repeating (or done if RPT_EN=0)
  logic [N_CH-1:0]   phase, phase_nxt;
  logic [N_CH-1:0]   level_nxt, press_nxt, rel_nxt, rpt_nxt;
  logic              evt_valid_nxt;
  logic [IDX_W-1:0]  evt_idx_nxt;

  // Per-channel filter and hold/repeat next-state logic
  always_comb begin
    level_nxt = level;
    scnt_nxt  = scnt;
    hcnt_nxt  = hcnt;
    phase_nxt = phase;
    press_nxt = '0;
    rel_nxt   = '0;
    rpt_nxt   = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (s2[i] == level[i]) begin
        scnt_nxt[i] = '0;
      end else if (tick) begin
        if (scnt[i] == SCNT_W'(STABLE_CYC - 1)) begin
          level_nxt[i] = s2[i];
          scnt_nxt[i]  = '0;
          press_nxt[i] = s2[i];
          rel_nxt[i]   = ~s2[i];
        end else begin
          scnt_nxt[i] = scnt[i] + SCNT_W'(1);
        end
      end
      // Looking at the next level keeps a repeat out of the release cycle
      if (!level_nxt[i] || press_nxt[i]) begin
        hcnt_nxt[i]  = '0;
        phase_nxt[i] = 1'b0;
      end else if (tick && !(!RPT_EN && phase[i])) begin
        if (hcnt[i] == (phase[i] ? HCNT_W'(RPT_CYC - 1) : HCNT_W'(HOLD_CYC - 1))) begin
          rpt_nxt[i]   = 1'b1;
          phase_nxt[i] = 1'b1;
          hcnt_nxt[i]  = RPT_EN ? '0 : HCNT_W'(HOLD_CYC);
        end else begin
          hcnt_nxt[i] = hcnt[i] + HCNT_W'(1);
        end
      end
    end
  end

  // Event encoder: lowest channel with a press or repeat in the previous cycle
  always_comb begin
    evt_valid_nxt = |(press | rpt);
    evt_idx_nxt   = evt_idx;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (press[i] || rpt[i]) evt_idx_nxt = IDX_W'(i);
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1        <= '0;
      s2        <= '0;
      scnt      <= '{default: '0};
      hcnt      <= '{default: '0};
      phase     <= '0;
      level     <= '0;
      press     <= '0;
      rel       <= '0;
      rpt       <= '0;
      evt_valid <= 1'b0;
      evt_idx   <= '0;
    end else begin
      s1        <= btn;
      s2        <= s1;
      scnt      <= scnt_nxt;
      hcnt      <= hcnt_nxt;
      phase     <= phase_nxt;
      level     <= level_nxt;
      press     <= press_nxt;
      rel       <= rel_nxt;
      rpt       <= rpt_nxt;
      evt_valid <= evt_valid_nxt;
      evt_idx   <= evt_idx_nxt;
    end
  end

endmodule
